// File: rtl/ft_nmr_checker_if.sv
// ---------------------------------------------------------------------------
// ft_nmr_checker_if
//   Bundle between the redundant cores and the N-modular-redundancy checker.
//   Per-core write tuples are packed, core k at slice [k*W +: W].
//
//   master : the core side  (drives writes/PC, receives recovery controls)
//   slave  : the checker    (receives writes/PC, drives recovery controls)
//
//   we_i          NUM_CORES             per-core register-file write enable
//   addr_i        NUM_CORES*ADDR_WIDTH  per-core write address
//   data_i        NUM_CORES*DATA_WIDTH  per-core write data
//   pc_i          DATA_WIDTH            core 0 program counter
//   pc_valid_i    1                     pc_i retired this cycle
//   spc_o         DATA_WIDTH            safe PC checkpoint
//   halt_o        1                     cores must stall
//   replay_we_o   1                     replay write strobe
//   replay_addr_o ADDR_WIDTH            replay address
//   replay_data_o DATA_WIDTH            replay data
//   resume_o      1                     one-cycle restart pulse
//   fault_core_o  NUM_CORES             one-hot outvoted core (TMR)
//   err_cnt_o     CNT_WIDTH             recoveries started (saturating)
//   corr_cnt_o    CNT_WIDTH             TMR masked faults (saturating)
// ---------------------------------------------------------------------------
interface ft_nmr_checker_if #(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_CORES-1:0]            we_i;
  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_CORES*DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0]           pc_i;
  logic                            pc_valid_i;

  logic [DATA_WIDTH-1:0]           spc_o;
  logic                            halt_o;
  logic                            replay_we_o;
  logic [ADDR_WIDTH-1:0]           replay_addr_o;
  logic [DATA_WIDTH-1:0]           replay_data_o;
  logic                            resume_o;
  logic [NUM_CORES-1:0]            fault_core_o;
  logic [CNT_WIDTH-1:0]            err_cnt_o;
  logic [CNT_WIDTH-1:0]            corr_cnt_o;

  modport master (
    output we_i, addr_i, data_i, pc_i, pc_valid_i,
    input  spc_o, halt_o, replay_we_o, replay_addr_o, replay_data_o,
           resume_o, fault_core_o, err_cnt_o, corr_cnt_o
  );

  modport slave (
    input  we_i, addr_i, data_i, pc_i, pc_valid_i,
    output spc_o, halt_o, replay_we_o, replay_addr_o, replay_data_o,
           resume_o, fault_core_o, err_cnt_o, corr_cnt_o
  );
endinterface

// File: rtl/ft_nmr_checker.sv
// ---------------------------------------------------------------------------
// ft_nmr_checker
//   Lock-step checker for 2 (DMR) or 3 (TMR) redundant cores. Each cycle in
//   IDLE it votes on the cores' register-file write tuples (we, addr, data).
//   Agreed writes are committed to a shadow register file and retired PCs
//   are checkpointed. A TMR single dissent is masked and reported; any
//   unrecoverable disagreement halts the cores, replays the whole shadow
//   file into them, then pulses resume so they restart from the checkpoint.
//
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : ft_nmr_checker_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module ft_nmr_checker #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CORES  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ft_nmr_checker_if.slave   bus
);

  if (NUM_CORES != 2 && NUM_CORES != 3) begin : g_bad_num_cores
    $error("ft_nmr_checker: NUM_CORES must be 2 or 3");
  end

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {IDLE, HALT, REPLAY, RESUME} state_e;

  // -------------------------------------------------------------------------
  // Unpack per-core tuples
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] core_addr [NUM_CORES];
  logic [DATA_WIDTH-1:0] core_data [NUM_CORES];

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
    assign core_addr[k] = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign core_data[k] = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Two tuples agree when the enables match and, if writing, addr/data match.
  function automatic logic agree(
    input logic                  we_a,
    input logic [ADDR_WIDTH-1:0] addr_a,
    input logic [DATA_WIDTH-1:0] data_a,
    input logic                  we_b,
    input logic [ADDR_WIDTH-1:0] addr_b,
    input logic [DATA_WIDTH-1:0] data_b
  );
    return (we_a == we_b) && (!we_a || ((addr_a == addr_b) && (data_a == data_b)));
  endfunction

  // -------------------------------------------------------------------------
  // Vote. maj_sel picks the tuple to commit: 0 -> core 0, 1 -> core 1.
  // -------------------------------------------------------------------------
  logic                 vote_ok;
  logic                 vote_err;
  logic                 vote_masked;
  logic                 maj_sel;
  logic [NUM_CORES-1:0] fault_vec;

  if (NUM_CORES == 3) begin : g_tmr
    logic a01, a02, a12;
    always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the if/else chain can leave one unassigned and infer a latch.
      vote_ok     = 1'b0;
      vote_err    = 1'b0;
      vote_masked = 1'b0;
      maj_sel     = 1'b0;
      fault_vec   = '0;
      a01 = agree(bus.we_i[0], core_addr[0], core_data[0],
                  bus.we_i[1], core_addr[1], core_data[1]);
      a02 = agree(bus.we_i[0], core_addr[0], core_data[0],
                  bus.we_i[2], core_addr[2], core_data[2]);
      a12 = agree(bus.we_i[1], core_addr[1], core_data[1],
                  bus.we_i[2], core_addr[2], core_data[2]);
      // Agreement is an equivalence, so a01 && a02 implies a12.
      if (a01 && a02) begin
        vote_ok = 1'b1;
      end else if (a01) begin
        vote_ok = 1'b1; vote_masked = 1'b1; fault_vec[2] = 1'b1;
      end else if (a02) begin
        vote_ok = 1'b1; vote_masked = 1'b1; fault_vec[1] = 1'b1;
      end else if (a12) begin
        vote_ok = 1'b1; vote_masked = 1'b1; fault_vec[0] = 1'b1; maj_sel = 1'b1;
      end else begin
        vote_err = 1'b1;
      end
    end
  end else begin : g_dmr
    always_comb begin
      vote_ok     = agree(bus.we_i[0], core_addr[0], core_data[0],
                          bus.we_i[1], core_addr[1], core_data[1]);
      vote_err    = !vote_ok;
      vote_masked = 1'b0;
      maj_sel     = 1'b0;
      fault_vec   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] spc_q, spc_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]  corr_cnt_q, corr_cnt_d;
  logic [NUM_CORES-1:0]  fault_core_q, fault_core_d;
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];

  logic                  in_idle;
  logic                  err_now;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE:   if (vote_err) state_d = HALT;
      HALT: begin
        state_d = REPLAY;
        ptr_d   = '0;
      end
      REPLAY: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == PTR_LAST) state_d = RESUME;
      end
      RESUME: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: commits, checkpoint, counters, fault flag
  always_comb begin
    in_idle     = (state_q == IDLE);
    err_now     = in_idle && vote_err;
    commit_addr = maj_sel ? core_addr[1] : core_addr[0];
    commit_data = maj_sel ? core_data[1] : core_data[0];
    // Entry 0 is hardwired to zero, so writes to it never commit.
    commit      = in_idle && vote_ok && (maj_sel ? bus.we_i[1] : bus.we_i[0])
                  && (commit_addr != '0);

    spc_d = (in_idle && bus.pc_valid_i && !vote_err) ? bus.pc_i : spc_q;

    err_cnt_d = err_cnt_q;
    if (err_now && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);

    corr_cnt_d = corr_cnt_q;
    if (in_idle && vote_masked && corr_cnt_q != CNT_MAX)
      corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);

    fault_core_d = (in_idle && vote_masked) ? fault_vec : '0;
  end

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      spc_q        <= '0;
      err_cnt_q    <= '0;
      corr_cnt_q   <= '0;
      fault_core_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      spc_q        <= spc_d;
      err_cnt_q    <= err_cnt_d;
      corr_cnt_q   <= corr_cnt_d;
      fault_core_q <= fault_core_d;
    end
  end

  // Shadow register file
  always_ff @(posedge clk_i) begin
    // NOTE: this storage is reset entry by entry because a recovery after
    // reset replays every entry, so none may hold stale data. That rules out
    // a plain RAM macro; it is built from flops.
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else if (commit) begin
      shadow_q[commit_addr] <= commit_data;
    end
  end

  // Outputs, forced to zero while reset is held
  always_comb begin
    bus.halt_o        = !rst_i && (state_q != IDLE);
    bus.replay_we_o   = !rst_i && (state_q == REPLAY);
    bus.replay_addr_o = bus.replay_we_o ? ptr_q : '0;
    bus.replay_data_o = bus.replay_we_o ? shadow_q[ptr_q] : '0;
    bus.resume_o      = !rst_i && (state_q == RESUME);
    bus.spc_o         = rst_i ? '0 : spc_q;
    bus.fault_core_o  = rst_i ? '0 : fault_core_q;
    bus.err_cnt_o     = rst_i ? '0 : err_cnt_q;
    bus.corr_cnt_o    = rst_i ? '0 : corr_cnt_q;
  end

endmodule

// File: tb/tb_ft_nmr_checker.sv
// ---------------------------------------------------------------------------
// tb_ft_nmr_checker
//   Directed bench for ft_nmr_checker: one DMR and one TMR instance share the
//   clock and reset. Inputs change 1 time unit after a rising edge; outputs
//   are sampled at that point, i.e. reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_ft_nmr_checker;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft_nmr_checker_if #(.NUM_CORES(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if_d ();
  ft_nmr_checker_if #(.NUM_CORES(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) if_t ();

  ft_nmr_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(2), .CNT_WIDTH(CW)) u_dmr (
    .clk_i(clk), .rst_i(rst), .bus(if_d.slave)
  );
  ft_nmr_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CORES(3), .CNT_WIDTH(CW)) u_tmr (
    .clk_i(clk), .rst_i(rst), .bus(if_t.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] mem_t [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [1:0] we, input logic [AW-1:0] a0, a1,
                       input logic [DW-1:0] d0, d1, input logic pcv, input logic [DW-1:0] pc);
    if_d.we_i       = we;
    if_d.addr_i     = {a1, a0};
    if_d.data_i     = {d1, d0};
    if_d.pc_valid_i = pcv;
    if_d.pc_i       = pc;
  endtask

  task automatic set_t(input logic [2:0] we, input logic [AW-1:0] a0, a1, a2,
                       input logic [DW-1:0] d0, d1, d2, input logic pcv, input logic [DW-1:0] pc);
    if_t.we_i       = we;
    if_t.addr_i     = {a2, a1, a0};
    if_t.data_i     = {d2, d1, d0};
    if_t.pc_valid_i = pcv;
    if_t.pc_i       = pc;
  endtask

  // Called with the DUT in REPLAY at pointer 0; returns with it in RESUME.
  task automatic sweep_d(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s_replay_%0d", tag, i),
            {if_d.halt_o, if_d.replay_we_o, if_d.replay_addr_o, if_d.replay_data_o},
            {1'b1, 1'b1, AW'(i), mem_d[i]});
      step();
    end
  endtask

  task automatic sweep_t(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("%s_replay_%0d", tag, i),
            {if_t.halt_o, if_t.replay_we_o, if_t.replay_addr_o, if_t.replay_data_o},
            {1'b1, 1'b1, AW'(i), mem_t[i]});
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = '0;
      mem_t[i] = '0;
    end
    set_d(2'b00, 0, 0, 0, 0, 1'b0, 0);
    set_t(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0);

    // ---- reset state ----
    step(); step();
    check("rst_halt_d",   if_d.halt_o, 0);
    check("rst_spc_d",    if_d.spc_o, 0);
    check("rst_errcnt_d", if_d.err_cnt_o, 0);
    check("rst_replay_d", {if_d.replay_we_o, if_d.replay_addr_o, if_d.replay_data_o, if_d.resume_o}, 0);
    check("rst_fault_t",  if_t.fault_core_o, 0);

    // ---- DMR agree on first cycle out of reset, PC 0x80 checkpointed ----
    rst = 1'b0;
    set_d(2'b11, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h80);
    mem_d[3] = 32'hDEADBEEF;
    step();
    check("agree_halt",   if_d.halt_o, 0);
    check("agree_spc",    if_d.spc_o, 32'h80);
    check("agree_errcnt", if_d.err_cnt_o, 0);

    // ---- DMR mismatch with pc_valid: error wins, spc holds ----
    set_d(2'b11, 5, 5, 32'h1, 32'h2, 1'b1, 32'h100);
    step();
    check("mm_halt",       if_d.halt_o, 1);
    check("mm_spc",        if_d.spc_o, 32'h80);
    check("mm_errcnt",     if_d.err_cnt_o, 1);
    check("mm_halt_noreplay", {if_d.replay_we_o, if_d.replay_addr_o, if_d.replay_data_o}, 0);
    // Mismatch stays on the inputs during recovery and must be ignored.
    step();
    sweep_d("mm");
    check("mm_resume",     {if_d.resume_o, if_d.halt_o}, 2'b11);
    check("mm_errcnt_hold", if_d.err_cnt_o, 1);
    set_d(2'b00, 0, 0, 0, 0, 1'b0, 0);
    step();
    check("mm_back_idle",  {if_d.resume_o, if_d.halt_o, if_d.replay_we_o}, 0);
    check("mm_spc_after",  if_d.spc_o, 32'h80);
    check("mm_errcnt_end", if_d.err_cnt_o, 1);

    // ---- TMR masked faults ----
    set_t(3'b111, 7, 7, 7, 32'h55, 32'h55, 32'hAA, 1'b1, 32'h200);
    mem_t[7] = 32'h55;
    step();
    check("tmr1_fault", if_t.fault_core_o, 3'b100);
    check("tmr1_corr",  if_t.corr_cnt_o, 1);
    check("tmr1_halt",  if_t.halt_o, 0);
    check("tmr1_spc",   if_t.spc_o, 32'h200);
    check("tmr1_err",   if_t.err_cnt_o, 0);
    set_t(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    step();
    check("tmr1_fault_clr", if_t.fault_core_o, 0);

    set_t(3'b111, 9, 9, 9, 32'h99, 32'h11, 32'h11, 1'b0, 0);
    mem_t[9] = 32'h11;
    step();
    check("tmr2_fault", if_t.fault_core_o, 3'b001);
    check("tmr2_corr",  if_t.corr_cnt_o, 2);

    set_t(3'b101, 10, 0, 10, 32'h33, 32'h0, 32'h33, 1'b0, 0);
    mem_t[10] = 32'h33;
    step();
    check("tmr3_fault", if_t.fault_core_o, 3'b010);
    check("tmr3_corr",  if_t.corr_cnt_o, 3);

    // All enables low: differing addr/data are ignored.
    set_t(3'b000, 1, 2, 3, 32'h4, 32'h5, 32'h6, 1'b0, 0);
    step();
    check("tmr_we0_fault", {if_t.fault_core_o, if_t.halt_o}, 0);
    check("tmr_we0_corr",  if_t.corr_cnt_o, 3);

    // Unanimous write to entry 0 must not commit.
    set_t(3'b111, 0, 0, 0, 32'hFF, 32'hFF, 32'hFF, 1'b0, 0);
    step();
    check("tmr_x0_halt", {if_t.fault_core_o, if_t.halt_o}, 0);

    // Triple disagreement with pc_valid: recovery, spc holds.
    set_t(3'b111, 1, 2, 4, 32'h77, 32'h77, 32'h77, 1'b1, 32'h300);
    step();
    check("tmr_triple_halt", if_t.halt_o, 1);
    check("tmr_triple_err",  if_t.err_cnt_o, 1);
    check("tmr_triple_spc",  if_t.spc_o, 32'h200);
    set_t(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    step();
    sweep_t("tmr");
    check("tmr_resume", if_t.resume_o, 1);
    step();
    check("tmr_idle", {if_t.resume_o, if_t.halt_o}, 0);

    // ---- reset mid-REPLAY ----
    set_d(2'b11, 5, 5, 32'h1, 32'h2, 1'b0, 0);
    step();
    check("abort_err2", if_d.err_cnt_o, 2);
    set_d(2'b00, 0, 0, 0, 0, 1'b0, 0);
    step();
    repeat (10) step();
    check("abort_ptr10", {if_d.replay_we_o, if_d.replay_addr_o}, {1'b1, AW'(10)});
    rst = 1'b1;
    step();
    check("abort_in_rst", {if_d.halt_o, if_d.resume_o, if_d.replay_we_o}, 0);
    rst = 1'b0;
    step();
    check("abort_halt",   {if_d.halt_o, if_d.resume_o}, 0);
    check("abort_spc",    if_d.spc_o, 0);
    check("abort_err",    if_d.err_cnt_o, 0);
    check("abort_tmr",    {if_t.corr_cnt_o, if_t.err_cnt_o, if_t.spc_o}, 0);

    // ---- saturation; the first recovery also shows the shadow was cleared ----
    for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
    for (int n = 0; n < 300; n++) begin
      set_d(2'b11, 5, 5, 32'h1, 32'h2, 1'b0, 0);
      step();
      set_d(2'b00, 0, 0, 0, 0, 1'b0, 0);
      step();
      if (n == 0) sweep_d("post_rst");
      else repeat (DEPTH) step();
      step();
      if (n == 254) check("sat_255", if_d.err_cnt_o, 255);
    end
    check("sat_300",  if_d.err_cnt_o, 255);
    check("sat_idle", if_d.halt_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
